redmule_tcdm_scheduler: RTL and testbench

- Arbitrates the single shared TCDM port of the RedMulE streamer between four requesters: X load (ch0), W load (ch1), Y load (ch2) and Z store (ch3).
- Replaces blind round-robin muxing with:
  - a locked, HCI-compliant selection;
  - Z-store urgency and starvation protection;
  - an in-order outstanding-read tracker that routes each TCDM response back to the load channel that issued it.
- Sits between the source/sink stream converters and the cast/TCDM path.

---
 rtl/redmule_tcdm_scheduler.sv | 326 ++++++++++++++++++++++++++++++++
 tb/tb_redmule_tcdm_scheduler.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/redmule_tcdm_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : redmule_tcdm_scheduler
//  Purpose  : Shares the single TCDM port of the RedMulE streamer between the
//             X, W and Y load channels and the Z store channel. The winner is
//             chosen with starvation protection, then Z urgency, then round
//             robin. A selection that is not granted at once stays locked
//             until the TCDM grants it (HCI-compliant: the request is never
//             withdrawn or re-targeted under the requester's feet). Read
//             grants are logged in an in-order FIFO so that each response is
//             routed back to the channel that issued it.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk_i           clock
//    rst_ni          asynchronous active-low reset
//    clear_i         synchronous soft clear (same effect as reset)
//    enable_i        arbitration enable (no new selection when low)
//    req_i[NCH]      per-channel request
//    wen_i[NCH]      per-channel write enable (1 = read, HCI polarity)
//    z_urgent_i      Z sink buffer almost full
//    gnt_o[NCH]      per-channel grant (one-hot or zero)
//    tcdm_req_o      request to TCDM
//    tcdm_gnt_i      TCDM grant
//    sel_o[CW]       channel currently driving the TCDM mux
//    tcdm_r_valid_i  TCDM read response valid (in order)
//    r_valid_o[NCH]  routed response valid (one-hot or zero)
//    r_sel_o[CW]     channel owning the current response
//    busy_o          selection locked or reads outstanding
//    err_o           sticky: response received with no read outstanding
//    perf_o          (REDMULE_SCHED_PERF_EN only) NCH grant counters followed
//                    by one stall counter, 32 bits each, saturating
//  Build option
//    REDMULE_SCHED_PERF_EN : adds perf_o and its counters
// ============================================================================
module redmule_tcdm_scheduler #(
  parameter int NCH         = 4,
  parameter int OUTSTANDING = 4,
  parameter int MAX_WAIT    = 16,
  parameter int CW          = $clog2(NCH)
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           clear_i,
  input  logic           enable_i,
  input  logic [NCH-1:0] req_i,
  input  logic [NCH-1:0] wen_i,
  input  logic           z_urgent_i,
  output logic [NCH-1:0] gnt_o,
  output logic           tcdm_req_o,
  input  logic           tcdm_gnt_i,
  output logic [CW-1:0]  sel_o,
  input  logic           tcdm_r_valid_i,
  output logic [NCH-1:0] r_valid_o,
  output logic [CW-1:0]  r_sel_o,
  output logic           busy_o,
  output logic           err_o
`ifdef REDMULE_SCHED_PERF_EN
  ,
  output logic [(NCH+1)*32-1:0] perf_o
`endif
);

  localparam int PW   = $clog2(OUTSTANDING);
  localparam int CNTW = PW + 1;
  localparam int WW   = $clog2(MAX_WAIT + 1);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   lock_sel_q;
  logic [CW-1:0]   rr_ptr_q;
  logic [WW-1:0]   wait_q [NCH];

  logic [CW-1:0]   fifo_q [OUTSTANDING];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNTW-1:0] count_q;
  logic            err_q;

  logic [NCH-1:0]  eligible;
  logic            any_eligible;
  logic            fifo_has_room;
  logic            starved_found;
  logic [CW-1:0]   starved_idx;
  logic            rr_found;
  logic [CW-1:0]   rr_idx;
  logic [CW:0]     rr_cand;
  logic [CW-1:0]   winner;

  logic [CW-1:0]   sel;
  logic            tcdm_req;
  logic            granted;
  logic            push;
  logic            pop_ok;
  logic [CW-1:0]   head;

  // --------------------------------------------------------------------------
  // Eligibility: reads need a free slot in the response FIFO, writes never do.
  // --------------------------------------------------------------------------
  assign fifo_has_room = (count_q < CNTW'(OUTSTANDING));

  always_comb begin
    eligible = '0;
    for (int i = 0; i < NCH; i++) begin
      eligible[i] = req_i[i] & (~wen_i[i] | fifo_has_room);
    end
  end

  assign any_eligible = |eligible;

  // --------------------------------------------------------------------------
  // Winner selection: starved (lowest index) > urgent Z > round robin.
  // Both searches walk downward so the last hit is the preferred one.
  // --------------------------------------------------------------------------
  always_comb begin
    starved_found = 1'b0;
    starved_idx   = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (eligible[i] && (wait_q[i] == WW'(MAX_WAIT))) begin
        starved_found = 1'b1;
        starved_idx   = CW'(i);
      end
    end

    rr_found = 1'b0;
    rr_idx   = '0;
    rr_cand  = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      // Modular add done one bit wider so non power-of-two NCH wraps too.
      rr_cand = {1'b0, rr_ptr_q} + (CW+1)'(k);
      if (rr_cand >= (CW+1)'(NCH)) begin
        rr_cand = rr_cand - (CW+1)'(NCH);
      end
      if (eligible[rr_cand[CW-1:0]]) begin
        rr_found = 1'b1;
        rr_idx   = rr_cand[CW-1:0];
      end
    end

    if (starved_found) begin
      winner = starved_idx;
    end else if (z_urgent_i && eligible[NCH-1]) begin
      winner = CW'(NCH - 1);
    end else if (rr_found) begin
      winner = rr_idx;
    end else begin
      winner = '0;
    end
  end

  // --------------------------------------------------------------------------
  // Lock FSM. IDLE selects and requests in the same cycle; an ungranted
  // selection is frozen in LOCKED until granted or the requester gives up.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      lock_sel_q <= '0;
    end else if (clear_i) begin
      state_q    <= IDLE;
      lock_sel_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE) begin
        lock_sel_q <= winner;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    sel      = '0;
    tcdm_req = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable_i && any_eligible && !clear_i) begin
          sel      = winner;
          tcdm_req = 1'b1;
          if (!tcdm_gnt_i) begin
            state_d = LOCKED;
          end
        end
      end
      LOCKED: begin
        sel      = lock_sel_q;
        tcdm_req = req_i[lock_sel_q] & ~clear_i;
        if (tcdm_gnt_i || !req_i[lock_sel_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign granted    = tcdm_req & tcdm_gnt_i;
  assign tcdm_req_o = tcdm_req;
  assign sel_o      = sel;

  always_comb begin
    gnt_o = '0;
    for (int i = 0; i < NCH; i++) begin
      gnt_o[i] = granted && (sel == CW'(i));
    end
  end

  // Round-robin pointer moves past the channel just served.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q <= '0;
    end else if (clear_i) begin
      rr_ptr_q <= '0;
    end else if (granted) begin
      rr_ptr_q <= (sel == CW'(NCH - 1)) ? '0 : sel + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Per-channel wait counters (saturating) for starvation detection.
  // --------------------------------------------------------------------------
  for (genvar g = 0; g < NCH; g++) begin : g_wait
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        wait_q[g] <= '0;
      end else if (clear_i) begin
        wait_q[g] <= '0;
      end else if (!req_i[g] || gnt_o[g]) begin
        wait_q[g] <= '0;
      end else if (wait_q[g] != WW'(MAX_WAIT)) begin
        wait_q[g] <= wait_q[g] + 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // In-order outstanding-read tracker. A response arriving with nothing
  // outstanding is not routed anywhere and raises the sticky error flag.
  // --------------------------------------------------------------------------
  assign push   = granted & wen_i[sel];
  assign pop_ok = tcdm_r_valid_i & (count_q != '0);
  assign head   = fifo_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= sel;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (push && !pop_ok) begin
        count_q <= count_q + 1'b1;
      end else if (!push && pop_ok) begin
        count_q <= count_q - 1'b1;
      end
      if (tcdm_r_valid_i && (count_q == '0)) begin
        err_q <= 1'b1;
      end
    end
  end

  always_comb begin
    r_valid_o = '0;
    for (int i = 0; i < NCH; i++) begin
      r_valid_o[i] = pop_ok && (head == CW'(i));
    end
  end

  assign r_sel_o = pop_ok ? head : '0;
  assign busy_o  = (state_q == LOCKED) | (count_q != '0);
  assign err_o   = err_q;

`ifdef REDMULE_SCHED_PERF_EN
  // --------------------------------------------------------------------------
  // Saturating performance counters: grants per channel, plus stall cycles
  // (request presented but not granted).
  // --------------------------------------------------------------------------
  logic [31:0] grant_cnt_q [NCH];
  logic [31:0] stall_cnt_q;

  for (genvar g = 0; g < NCH; g++) begin : g_perf
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        grant_cnt_q[g] <= '0;
      end else if (clear_i) begin
        grant_cnt_q[g] <= '0;
      end else if (gnt_o[g] && !(&grant_cnt_q[g])) begin
        grant_cnt_q[g] <= grant_cnt_q[g] + 1'b1;
      end
    end
    assign perf_o[g*32 +: 32] = grant_cnt_q[g];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
    end else if (clear_i) begin
      stall_cnt_q <= '0;
    end else if (tcdm_req && !tcdm_gnt_i && !(&stall_cnt_q)) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign perf_o[NCH*32 +: 32] = stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_redmule_tcdm_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_redmule_tcdm_scheduler
//  Purpose  : Directed self-checking bench for redmule_tcdm_scheduler with
//             hand-computed expected values (default parameters).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_redmule_tcdm_scheduler;

  localparam int NCH = 4;
  localparam int CW  = 2;

  logic           clk;
  logic           rst_n;
  logic           clear;
  logic           enable;
  logic [NCH-1:0] req;
  logic [NCH-1:0] wen;
  logic           z_urgent;
  logic [NCH-1:0] gnt;
  logic           tcdm_req;
  logic           tcdm_gnt;
  logic [CW-1:0]  sel;
  logic           tcdm_r_valid;
  logic [NCH-1:0] r_valid;
  logic [CW-1:0]  r_sel;
  logic           busy;
  logic           err;

  int total = 0;
  int bad   = 0;

  redmule_tcdm_scheduler #(
    .NCH(4), .OUTSTANDING(4), .MAX_WAIT(16)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .clear_i        (clear),
    .enable_i       (enable),
    .req_i          (req),
    .wen_i          (wen),
    .z_urgent_i     (z_urgent),
    .gnt_o          (gnt),
    .tcdm_req_o     (tcdm_req),
    .tcdm_gnt_i     (tcdm_gnt),
    .sel_o          (sel),
    .tcdm_r_valid_i (tcdm_r_valid),
    .r_valid_o      (r_valid),
    .r_sel_o        (r_sel),
    .busy_o         (busy),
    .err_o          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled on
  // the falling edge, well away from the active edge.
  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic do_clear();
    req = '0; wen = '0; tcdm_gnt = 1'b0; tcdm_r_valid = 1'b0; z_urgent = 1'b0;
    clear = 1'b1;
    adv();
    clear = 1'b0;
  endtask

  logic [3:0] t1_gnt [5] = '{4'h1, 4'h2, 4'h4, 4'h1, 4'h2};
  logic [3:0] t1_rv  [5] = '{4'h0, 4'h0, 4'h1, 4'h2, 4'h4};
  logic [3:0] t3_gnt [4] = '{4'h1, 4'h2, 4'h4, 4'h1};
  logic [3:0] t3_rv  [4] = '{4'h2, 4'h4, 4'h1, 4'h1};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; clear = 1'b0; enable = 1'b1; req = '0; wen = '0;
    z_urgent = 1'b0; tcdm_gnt = 1'b0; tcdm_r_valid = 1'b0;

    // ---------------- reset state ----------------
    #12;
    check_eq("rst_tcdm_req", {31'd0, tcdm_req}, 32'd0);
    check_eq("rst_gnt",      {28'd0, gnt},      32'd0);
    check_eq("rst_busy",     {31'd0, busy},     32'd0);
    check_eq("rst_err",      {31'd0, err},      32'd0);
    check_eq("rst_rvalid",   {28'd0, r_valid},  32'd0);
    adv();
    rst_n = 1'b1;

    // ---------------- T1: round robin X,W,Y with in-order responses -------
    req = 4'b0111; wen = 4'b0111; tcdm_gnt = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tcdm_r_valid = (c >= 2);
      settle();
      check_eq("t1_gnt",    {28'd0, gnt},     {28'd0, t1_gnt[c]});
      check_eq("t1_rvalid", {28'd0, r_valid}, {28'd0, t1_rv[c]});
      adv();
    end
    req = '0; tcdm_r_valid = 1'b1;
    settle();
    check_eq("t1_drain0", {28'd0, r_valid}, 32'h1);
    adv();
    settle();
    check_eq("t1_drain1", {28'd0, r_valid}, 32'h2);
    check_eq("t1_rsel1",  {30'd0, r_sel},   32'd1);
    adv();
    tcdm_r_valid = 1'b0;
    settle();
    check_eq("t1_idle_busy", {31'd0, busy}, 32'd0);
    adv();

    // ---------------- T2: Y locked while TCDM stalls ----------------------
    do_clear();
    req = 4'b0100; wen = 4'b0111; tcdm_gnt = 1'b0;
    settle();
    check_eq("t2_sel_first", {30'd0, sel}, 32'd2);
    adv();
    req = 4'b0111;
    for (int c = 1; c < 5; c++) begin
      settle();
      check_eq("t2_sel_locked", {30'd0, sel},      32'd2);
      check_eq("t2_no_gnt",     {28'd0, gnt},      32'd0);
      check_eq("t2_req_held",   {31'd0, tcdm_req}, 32'd1);
      adv();
    end
    check_eq("t2_busy_locked", {31'd0, busy}, 32'd1);
    tcdm_gnt = 1'b1;
    settle();
    check_eq("t2_gnt_y", {28'd0, gnt}, 32'h4);
    adv();
    // Pointer now at 3: with everyone requesting, Z comes first.
    req = 4'b1111; wen = 4'b0111;
    settle();
    check_eq("t2_ptr3_gnt_z", {28'd0, gnt}, 32'h8);
    adv();
    req = '0; tcdm_gnt = 1'b0; tcdm_r_valid = 1'b1;
    settle();
    check_eq("t2_resp_y", {28'd0, r_valid}, 32'h4);
    check_eq("t2_rsel_y", {30'd0, r_sel},   32'd2);
    adv();
    tcdm_r_valid = 1'b0;

    // ---------------- T3: FIFO full blocks reads, not writes --------------
    do_clear();
    req = 4'b0111; wen = 4'b0111; tcdm_gnt = 1'b1;
    for (int c = 0; c < 4; c++) begin
      settle();
      check_eq("t3_fill_gnt", {28'd0, gnt}, {28'd0, t3_gnt[c]});
      adv();
    end
    req = 4'b1001; wen = 4'b0001;
    settle();
    check_eq("t3_z_over_blocked_x", {28'd0, gnt}, 32'h8);
    adv();
    req = 4'b0001; tcdm_r_valid = 1'b1;
    settle();
    check_eq("t3_x_blocked", {31'd0, tcdm_req}, 32'd0);
    check_eq("t3_resp0",     {28'd0, r_valid},  32'h1);
    adv();
    tcdm_r_valid = 1'b0;
    settle();
    check_eq("t3_x_after_resp", {28'd0, gnt}, 32'h1);
    adv();
    req = '0; tcdm_gnt = 1'b0; tcdm_r_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      settle();
      check_eq("t3_drain", {28'd0, r_valid}, {28'd0, t3_rv[c]});
      adv();
    end
    tcdm_r_valid = 1'b0;
    settle();
    check_eq("t3_busy_end", {31'd0, busy}, 32'd0);
    adv();

    // ---------------- T4: Z urgency, then starvation override -------------
    do_clear();
    req = 4'b1111; wen = 4'b0111; tcdm_gnt = 1'b1; z_urgent = 1'b1;
    for (int c = 0; c < 16; c++) begin
      settle();
      check_eq("t4_urgent_z", {28'd0, gnt}, 32'h8);
      adv();
    end
    settle();
    check_eq("t4_starved_x", {28'd0, gnt}, 32'h1);
    adv();
    settle();
    check_eq("t4_starved_w", {28'd0, gnt}, 32'h2);
    adv();
    settle();
    check_eq("t4_starved_y", {28'd0, gnt}, 32'h4);
    adv();

    // ---------------- T5: response with empty FIFO ------------------------
    do_clear();
    tcdm_r_valid = 1'b1;
    settle();
    check_eq("t5_no_rvalid", {28'd0, r_valid}, 32'd0);
    adv();
    tcdm_r_valid = 1'b0;
    settle();
    check_eq("t5_err_set", {31'd0, err}, 32'd1);
    adv();
    settle();
    check_eq("t5_err_sticky", {31'd0, err}, 32'd1);
    adv();
    do_clear();
    settle();
    check_eq("t5_err_cleared", {31'd0, err}, 32'd0);
    adv();

    // ---------------- T6: async reset while locked with reads in flight ---
    do_clear();
    req = 4'b0011; wen = 4'b0011; tcdm_gnt = 1'b1;
    adv();
    adv();
    req = 4'b0100; wen = 4'b0100; tcdm_gnt = 1'b0;
    settle();
    check_eq("t6_sel_y", {30'd0, sel}, 32'd2);
    adv();
    settle();
    check_eq("t6_busy_locked", {31'd0, busy}, 32'd1);
    rst_n = 1'b0; req = '0;
    #1;
    check_eq("t6_rst_tcdm_req", {31'd0, tcdm_req}, 32'd0);
    check_eq("t6_rst_busy",     {31'd0, busy},     32'd0);
    check_eq("t6_rst_sel",      {30'd0, sel},      32'd0);
    check_eq("t6_rst_gnt",      {28'd0, gnt},      32'd0);
    adv();
    rst_n = 1'b1;
    settle();
    check_eq("t6_post_req", {31'd0, tcdm_req}, 32'd0);
    adv();
    tcdm_r_valid = 1'b1;
    settle();
    check_eq("t6_dropped_rvalid", {28'd0, r_valid}, 32'd0);
    adv();
    tcdm_r_valid = 1'b0;
    settle();
    check_eq("t6_dropped_err", {31'd0, err}, 32'd1);
    adv();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
